// File: rtl/onehot_req_serializer_pkg.sv
// Shared constants and helpers for the one-hot request serializer.
// Arbitration mode encodings, index-width calculation and the one-hot test.
package onehot_req_serializer_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Widest request vector the one-hot helper accepts; callers zero-extend into it.
  localparam int MAX_N = 64;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic logic is_onehot(input logic [MAX_N-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_req_serializer_prio_enc_rr.sv
// Combinational priority encoder with an optional round-robin start point.
// Round-robin uses two passes: the upper masked vector first, then the full vector as wrap-around.
module prio_enc_rr
  import onehot_req_serializer_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] rr_ptr,
  input  logic         mode,
  output logic [W-1:0] index,
  output logic         any
);

  logic [N-1:0] upper;
  logic [N-1:0] masked;
  logic [W-1:0] idx_masked;
  logic [W-1:0] idx_all;
  logic         any_masked;

  always_comb begin
    upper      = '0;
    idx_masked = '0;
    idx_all    = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = (i >= int'(rr_ptr));
    end
    masked = mode ? (cand & upper) : cand;
    // Scanning downward leaves the lowest set index as the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) idx_masked = W'(i);
      if (cand[i])   idx_all    = W'(i);
    end
    any_masked = |masked;
    any        = |cand;
    index      = any_masked ? idx_masked : idx_all;
  end

endmodule

// File: rtl/onehot_req_serializer.sv
// Latches request strobes into a sticky pending register and streams their binary
// indices out over a valid/ready handshake, in fixed or round-robin order (N up to 64).
module onehot_req_serializer
  import onehot_req_serializer_pkg::*;
#(
  parameter  int N            = 8,
  parameter  int ARB_MODE     = ARB_RR,
  parameter  int CHECK_ONEHOT = 1,
  localparam int W            = clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_in,
  input  logic         req_valid,
  output logic [W-1:0] idx_out,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [N-1:0] pending,
  output logic         busy,
  output logic         multi_err
);

  logic [N-1:0] pend;
  logic [N-1:0] clr;
  logic [N-1:0] set;
  logic [N-1:0] cand;
  logic         fire;
  logic         load;
  logic         accepted;
  logic         pick_any;
  logic [W-1:0] pick;
  logic [W-1:0] rr_ptr;
  logic [W-1:0] ptr_next;
  logic         mode_rr;

  assign mode_rr = (ARB_MODE == ARB_RR);

  // Candidates exclude this cycle's strobe, so a set-wins re-request is issued on a later load.
  always_comb begin
    fire     = idx_valid & idx_ready;
    clr      = fire ? (N'(1) << idx_out) : '0;
    accepted = (CHECK_ONEHOT == 0) || is_onehot(MAX_N'(req_in));
    set      = (req_valid && accepted) ? req_in : '0;
    cand     = pend & ~clr;
    load     = !idx_valid || fire;
    ptr_next = (int'(pick) == N - 1) ? '0 : pick + 1'b1;
  end

  prio_enc_rr #(.N(N)) u_prio (
    .cand   (cand),
    .rr_ptr (rr_ptr),
    .mode   (mode_rr),
    .index  (pick),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      rr_ptr    <= '0;
      multi_err <= 1'b0;
    end else begin
      pend      <= cand | set;
      multi_err <= (CHECK_ONEHOT != 0) && req_valid && !accepted;
      if (load) begin
        if (pick_any) begin
          idx_out   <= pick;
          idx_valid <= 1'b1;
          rr_ptr    <= ptr_next;
        end else begin
          idx_valid <= 1'b0;
        end
      end
    end
  end

  assign pending = pend;
  assign busy    = |pend;

endmodule
